// File: rtl/tns_enc_seq_28.sv
// +--------------------------------------------------------------------------+
// | tns_enc_seq_28                                                           |
// | Sequential 28-bit TNS encoder: greedy MSB-first subtraction of the TNS   |
// | level weights, one code bit resolved per clock, valid/ready on both     |
// | sides, one word in flight.                                               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

// TNS level weights. Each weight is the sum of the three below it, which
// keeps every weight no larger than one plus the sum of all lower weights,
// so the greedy walk reaches zero for any value up to the total.
package tns_enc_seq_28_pkg;
  localparam int unsigned BLEN10_C = 26;

  localparam int unsigned TNS01_C = 32'd1;
  localparam int unsigned TNS01_B = 32'd2;
  localparam int unsigned TNS01_A = 32'd4;
  localparam int unsigned TNS02_C = 32'd7;
  localparam int unsigned TNS02_B = 32'd13;
  localparam int unsigned TNS02_A = 32'd24;
  localparam int unsigned TNS03_C = 32'd44;
  localparam int unsigned TNS03_B = 32'd81;
  localparam int unsigned TNS03_A = 32'd149;
  localparam int unsigned TNS04_C = 32'd274;
  localparam int unsigned TNS04_B = 32'd504;
  localparam int unsigned TNS04_A = 32'd927;
  localparam int unsigned TNS05_C = 32'd1705;
  localparam int unsigned TNS05_B = 32'd3136;
  localparam int unsigned TNS05_A = 32'd5768;
  localparam int unsigned TNS06_C = 32'd10609;
  localparam int unsigned TNS06_B = 32'd19513;
  localparam int unsigned TNS06_A = 32'd35890;
  localparam int unsigned TNS07_C = 32'd66012;
  localparam int unsigned TNS07_B = 32'd121415;
  localparam int unsigned TNS07_A = 32'd223317;
  localparam int unsigned TNS08_C = 32'd410744;
  localparam int unsigned TNS08_B = 32'd755476;
  localparam int unsigned TNS08_A = 32'd1389537;
  localparam int unsigned TNS09_C = 32'd2555757;
  localparam int unsigned TNS09_B = 32'd4700770;
  localparam int unsigned TNS09_A = 32'd8646064;
  localparam int unsigned TNS10_C = 32'd15902591;
endpackage

module tns_enc_seq_28
  import tns_enc_seq_28_pkg::*;
#(
  parameter int DW = BLEN10_C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] datain,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [27:0]   codeout,
  output logic          out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Constant weight mux indexed by the bit counter.
  function automatic logic [DW-1:0] weight_f(input logic [4:0] i);
    case (i)
      5'd0:    weight_f = DW'(TNS01_C);
      5'd1:    weight_f = DW'(TNS01_B);
      5'd2:    weight_f = DW'(TNS01_A);
      5'd3:    weight_f = DW'(TNS02_C);
      5'd4:    weight_f = DW'(TNS02_B);
      5'd5:    weight_f = DW'(TNS02_A);
      5'd6:    weight_f = DW'(TNS03_C);
      5'd7:    weight_f = DW'(TNS03_B);
      5'd8:    weight_f = DW'(TNS03_A);
      5'd9:    weight_f = DW'(TNS04_C);
      5'd10:   weight_f = DW'(TNS04_B);
      5'd11:   weight_f = DW'(TNS04_A);
      5'd12:   weight_f = DW'(TNS05_C);
      5'd13:   weight_f = DW'(TNS05_B);
      5'd14:   weight_f = DW'(TNS05_A);
      5'd15:   weight_f = DW'(TNS06_C);
      5'd16:   weight_f = DW'(TNS06_B);
      5'd17:   weight_f = DW'(TNS06_A);
      5'd18:   weight_f = DW'(TNS07_C);
      5'd19:   weight_f = DW'(TNS07_B);
      5'd20:   weight_f = DW'(TNS07_A);
      5'd21:   weight_f = DW'(TNS08_C);
      5'd22:   weight_f = DW'(TNS08_B);
      5'd23:   weight_f = DW'(TNS08_A);
      5'd24:   weight_f = DW'(TNS09_C);
      5'd25:   weight_f = DW'(TNS09_B);
      5'd26:   weight_f = DW'(TNS09_A);
      5'd27:   weight_f = DW'(TNS10_C);
      default: weight_f = '0;
    endcase
  endfunction

  logic [1:0]    sync_q;
  logic          rst_core_n;
  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [27:0]   code_q, code_d;
  logic [DW-1:0] w_weight;
  logic          w_take;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_core_n = sync_q[1];

  assign w_weight = weight_f(idx_q);
  assign w_take   = (rem_q >= w_weight);

  // State, bit counter, residual and code registers.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      rem_q   <= '0;
      code_q  <= 28'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic: load on accept, resolve one bit per BUSY cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = datain;
          code_d  = 28'd0;
          idx_d   = 5'd27;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (w_take) begin
          code_d[idx_q] = 1'b1;
          rem_d         = rem_q - w_weight;
        end
        if (idx_q == 5'd0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign codeout   = code_q;
  assign out_err   = out_valid && (rem_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_tns_enc_seq_28.sv
`default_nettype none

module tb_tns_enc_seq_28;

  localparam int DW = tns_enc_seq_28_pkg::BLEN10_C;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] datain;
  logic          out_valid;
  logic          out_ready;
  logic [27:0]   codeout;
  logic          out_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Independent copy of the weight ladder (each entry is the sum of the three below).
  int unsigned w_tab [28] = '{
    1, 2, 4, 7, 13, 24, 44, 81, 149, 274, 504, 927, 1705, 3136, 5768,
    10609, 19513, 35890, 66012, 121415, 223317, 410744, 755476, 1389537,
    2555757, 4700770, 8646064, 15902591
  };

  typedef struct {
    string         name;
    logic [DW-1:0] d;
    logic [27:0]   code;
    logic          err;
  } vec_t;

  vec_t vecs [12];

  tns_enc_seq_28 #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeout   (codeout),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Push one word through with out_ready high; returns result, latency and accept cycle.
  task automatic run_word(input logic [DW-1:0] d, output logic [27:0] c,
                          output logic e, output int lat, output int acc);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    datain   = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc = cyc;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 60);
    c = codeout;
    e = out_err;
    if (out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [27:0] c, c0;
    logic        e, e0;
    int          lat, acc, prev_acc, bad;
    longint      sum, s;
    logic [DW-1:0] d;

    sum = 0;
    for (int i = 0; i < 28; i++) sum += longint'(w_tab[i]);

    vecs[0]  = '{"zero",      DW'(0),            28'h0000000, 1'b0};
    vecs[1]  = '{"tns01_c",   DW'(1),            28'h0000001, 1'b0};
    vecs[2]  = '{"two",       DW'(2),            28'h0000002, 1'b0};
    vecs[3]  = '{"three",     DW'(3),            28'h0000003, 1'b0};
    vecs[4]  = '{"six",       DW'(6),            28'h0000006, 1'b0};
    vecs[5]  = '{"seven",     DW'(7),            28'h0000008, 1'b0};
    vecs[6]  = '{"twelve",    DW'(12),           28'h000000D, 1'b0};
    vecs[7]  = '{"w9_plus1",  DW'(275),          28'h0000201, 1'b0};
    vecs[8]  = '{"tns05_b",   DW'(3136),         28'h0002000, 1'b0};
    vecs[9]  = '{"tns10_c",   DW'(15902591),     28'h8000000, 1'b0};
    vecs[10] = '{"sum_all",   DW'(sum),          28'hFFFFFFF, 1'b0};
    vecs[11] = '{"sum_plus1", DW'(sum + 1),      28'hFFFFFFF, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    datain    = '0;

    #3;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_codeout",   codeout,   0);
    chk("rst_out_err",   out_err,   0);

    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven directed vectors.
    for (int i = 0; i < 12; i++) begin
      if (i < 11 || (sum + 1) < (longint'(1) << DW)) begin
        run_word(vecs[i].d, c, e, lat, acc);
        chk({vecs[i].name, "_code"}, c,   vecs[i].code);
        chk({vecs[i].name, "_err"},  e,   vecs[i].err);
        chk({vecs[i].name, "_lat"},  lat, 28);
      end
    end

    // Reset asserted in the middle of BUSY.
    in_valid = 1'b1;
    datain   = DW'(15902591);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_codeout",   codeout,   0);
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_out_err",   out_err,   0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    datain   = '0;
    @(posedge clk); #1;
    chk("sync_edge1_in_ready", in_ready, 1);
    chk("sync_edge1_valid",    out_valid, 0);
    @(posedge clk); #1;
    chk("sync_edge2_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("sync_edge3_accept",   in_ready, 0);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 60);
    chk("postrst_zero_lat",  lat,     28);
    chk("postrst_zero_code", codeout, 0);
    chk("postrst_zero_err",  out_err, 0);
    @(posedge clk); #1;

    // Backpressure: hold the result for 50 cycles and ignore a new input pulse.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    datain    = DW'(15902591);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 60);
    chk("bp_lat", lat, 28);
    c0 = codeout;
    e0 = out_err;
    chk("bp_code", c0, 28'h8000000);
    chk("bp_err",  e0, 0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (!out_valid || codeout !== c0 || out_err !== e0 || in_ready) bad++;
      if (k == 10) begin
        in_valid = 1'b1;
        datain   = DW'(5);
      end
      if (k == 11) in_valid = 1'b0;
    end
    chk("bp_hold_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  in_ready,  1);
    chk("bp_release_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("bp_pulse_ignored", in_ready, 1);

    // Random round trip at full throughput.
    prev_acc = -1;
    for (int i = 0; i < 300; i++) begin
      d = DW'($urandom_range(0, 32'(sum)));
      run_word(d, c, e, lat, acc);
      s = 0;
      for (int b = 0; b < 28; b++) if (c[b]) s += longint'(w_tab[b]);
      chk("rt_value", s, longint'(d));
      chk("rt_err",   e, 0);
      chk("rt_lat",   lat, 28);
      if (prev_acc >= 0) chk("rt_spacing", acc - prev_acc, 30);
      prev_acc = acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
